// File: rtl/iob_regfile_2p_reader_pkg.sv
// Shared definitions for the register-file scan reader: FSM state width and encodings.
package iob_regfile_2p_reader_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/iob_reg_e.sv
// Clock-enabled register with enable and asynchronous active-low reset to zero.
module iob_reg_e #(
  parameter int DATA_W = 1
) (
  input  logic              clk_i,
  input  logic              cke_i,
  input  logic              arst_n_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o
);

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      data_o <= '0;
    end else if (cke_i && en_i) begin
      data_o <= data_i;
    end
  end

endmodule

// File: rtl/iob_regfile_2p_reader.sv
// Scans a contiguous, wrapping range of register-file entries out as a valid/ready stream.
// Stream handshake: a beat transfers on a clk_i edge with cke_i high where m_valid_o & m_ready_i;
// once m_valid_o rises, data/addr/last stay stable until that transfer (or an abort/reset).
module iob_regfile_2p_reader
  import iob_regfile_2p_reader_pkg::*;
#(
  parameter int N       = 16,
  parameter int W       = 32,
  parameter int RADDR_W = $clog2(N)
) (
  input  logic               clk_i,
  input  logic               cke_i,
  input  logic               arst_n_i,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [RADDR_W-1:0] first_i,
  input  logic [RADDR_W:0]   count_i,
  output logic [RADDR_W-1:0] raddr_o,
  input  logic [W-1:0]       rdata_i,
  output logic               m_valid_o,
  input  logic               m_ready_i,
  output logic [W-1:0]       m_data_o,
  output logic [RADDR_W-1:0] m_addr_o,
  output logic               m_last_o,
  output logic               busy_o,
  output logic               done_o
);

  state_t               r_state;
  logic [RADDR_W-1:0]   r_addr;
  logic [RADDR_W:0]     r_remain;
  logic                 r_valid;
  logic                 r_done;

  logic                 w_cap;
  logic                 w_last;
  logic                 w_last_q;
  logic [RADDR_W-1:0]   w_addr_nxt;
  logic [W+RADDR_W:0]   w_out_q;

  assign w_cap      = (r_state == ST_READ) && (!r_valid || m_ready_i) && !abort_i;
  assign w_last     = (r_remain == (RADDR_W+1)'(1));
  assign w_addr_nxt = (r_addr == RADDR_W'(N-1)) ? '0 : r_addr + RADDR_W'(1);

  // Output beat register: value, its index and the last flag are captured together.
  iob_reg_e #(
    .DATA_W(W+RADDR_W+1)
  ) u_out_reg (
    .clk_i   (clk_i),
    .cke_i   (cke_i),
    .arst_n_i(arst_n_i),
    .en_i    (w_cap),
    .data_i  ({w_last, r_addr, rdata_i}),
    .data_o  (w_out_q)
  );

  assign w_last_q = w_out_q[W+RADDR_W];
  assign m_addr_o = w_out_q[W+RADDR_W-1:W];
  assign m_data_o = w_out_q[W-1:0];

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_state  <= ST_IDLE;
      r_addr   <= '0;
      r_remain <= '0;
      r_valid  <= 1'b0;
      r_done   <= 1'b0;
    end else if (cke_i) begin
      r_done <= 1'b0;
      if (abort_i) begin
        r_state <= ST_IDLE;
        r_valid <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start_i) begin
              if (count_i == '0) begin
                r_done <= 1'b1;
              end else begin
                r_state  <= ST_READ;
                r_addr   <= first_i;
                r_remain <= count_i;
              end
            end
          end
          ST_READ: begin
            if (w_cap) begin
              r_valid  <= 1'b1;
              r_addr   <= w_addr_nxt;
              r_remain <= r_remain - (RADDR_W+1)'(1);
              if (w_last) r_state <= ST_DRAIN;
            end
          end
          ST_DRAIN: begin
            if (r_valid && m_ready_i) begin
              r_valid <= 1'b0;
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign raddr_o   = r_addr;
  assign m_valid_o = r_valid;
  // The stored last flag outlives its beat; gate it so it is only seen on a valid beat.
  assign m_last_o  = w_last_q & r_valid;
  assign busy_o    = (r_state != ST_IDLE);
  assign done_o    = r_done;

endmodule

// File: tb/tb_iob_regfile_2p_reader.sv
// Randomized bench for iob_regfile_2p_reader against a queue-based model of the scanned beats.
module tb_iob_regfile_2p_reader;

  localparam int N  = 16;
  localparam int W  = 32;
  localparam int AW = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          cke, start, abort, m_ready;
  logic [AW-1:0] first;
  logic [AW:0]   count;
  logic [AW-1:0] raddr, m_addr;
  logic [W-1:0]  rdata, m_data;
  logic          m_valid, m_last, busy, done;

  logic [W-1:0]  mem [N];
  assign rdata = mem[raddr];

  iob_regfile_2p_reader #(.N(N), .W(W), .RADDR_W(AW)) dut (
    .clk_i    (clk),
    .cke_i    (cke),
    .arst_n_i (rst_n),
    .start_i  (start),
    .abort_i  (abort),
    .first_i  (first),
    .count_i  (count),
    .raddr_o  (raddr),
    .rdata_i  (rdata),
    .m_valid_o(m_valid),
    .m_ready_i(m_ready),
    .m_data_o (m_data),
    .m_addr_o (m_addr),
    .m_last_o (m_last),
    .busy_o   (busy),
    .done_o   (done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // scoreboard: {last, addr, data} of every beat still owed
  logic [36:0] exp_q[$];
  logic        done_exp   = 1'b0;
  logic        zero_start = 1'b0;
  logic        stall_prev = 1'b0;
  logic [40:0] snap;

  always @(negedge clk) begin
    logic [36:0] e;
    logic        acc;
    if (!rst_n) begin
      done_exp   = 1'b0;
      stall_prev = 1'b0;
    end else begin
      check("done", done, done_exp);
      if (m_last && !m_valid) check("last_gated", m_last, 0);
      if (stall_prev) check("stall_hold", {m_last, m_addr, m_data, raddr}, snap);
      acc = m_valid && m_ready && cke && !abort;
      if (cke) done_exp = zero_start && !abort;
      if (acc) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", {m_last, m_addr, m_data}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("beat", {m_last, m_addr, m_data}, e);
          if (e[36]) done_exp = 1'b1;
        end
      end
      stall_prev = m_valid && !m_ready && !abort;
      snap       = {m_last, m_addr, m_data, raddr};
    end
  end

  task automatic push_expected(input int f, input int c);
    for (int i = 0; i < c; i++) begin
      int a;
      a = (f + i) % N;
      exp_q.push_back({1'(i == c - 1), 4'(a), mem[a]});
    end
  endtask

  // mode 0: ready always high; 1: ready 1,0,0 with writes to captured entries; 2: random ready/cke/start
  task automatic run_scan(input int f, input int c, input int mode);
    int cyc;
    push_expected(f, c);
    cke = 1'b1; m_ready = 1'b1; start = 1'b1;
    first = 4'(f); count = 5'(c); zero_start = (c == 0);
    @(posedge clk); #1;
    start = 1'b0; zero_start = 1'b0;
    check("busy_after_start", busy, c != 0);
    if (mode == 0 && c != 0) check("first_lat_c0", m_valid, 0);
    cyc = 0;
    while (busy && cyc < 300) begin
      if (mode == 1) begin
        m_ready = (cyc % 3 == 0);
        if (m_valid && !m_ready) mem[m_addr] = $urandom;
      end
      if (mode == 2) begin
        m_ready = 1'($urandom_range(0, 1));
        cke     = ($urandom_range(0, 3) != 0);
        start   = 1'($urandom_range(0, 1));
        count   = 5'($urandom_range(0, 16));
        first   = 4'($urandom_range(0, 15));
      end
      @(posedge clk); #1;
      cyc++;
      if (mode == 0 && cyc == 1) check("first_lat_c1", m_valid, 1);
    end
    start = 1'b0; cke = 1'b1; m_ready = 1'b1;
    if (cyc >= 300) check("timeout", busy, 0);
    if (mode == 0 && c != 0) check("throughput_cycles", cyc, c + 1);
    repeat (2) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    check("idle_valid", m_valid, 0);
    check("idle_busy", busy, 0);
    exp_q.delete();
  endtask

  initial begin
    cke = 1'b1; rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    first = '0; count = '0; m_ready = 1'b1;
    for (int i = 0; i < N; i++) mem[i] = $urandom;

    #12;
    check("rst_outputs", {raddr, m_valid, m_data, m_addr, m_last, busy, done}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_scan(0, 16, 0);
    run_scan(14, 4, 0);
    run_scan(3, 3, 1);
    run_scan(0, 0, 0);

    // abort while the second beat is on the bus
    push_expected(5, 8);
    start = 1'b1; first = 4'd5; count = 5'd8;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_valid", m_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_beats_left", exp_q.size(), 7);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    run_scan(9, 2, 0);

    // asynchronous reset in the middle of a scan
    push_expected(2, 8);
    start = 1'b1; first = 4'd2; count = 5'd8;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async", {raddr, m_valid, m_data, m_addr, m_last, busy, done}, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_scan(11, 5, 0);

    for (int k = 0; k < 8; k++) begin
      run_scan($urandom_range(0, 15), $urandom_range(0, 16), $urandom_range(0, 2));
    end
    run_scan(7, 16, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
